// File: rtl/supercar_seq.sv
// supercar_seq: prescaled bounce FSM driving an up/down loadable counter into a one-hot LED scan; SUPERCAR_TRAIL_EN adds a 2-LED trail
module supercar_seq #(
  parameter int N_BIT       = 4,
  parameter int MAX_POS     = 7,
  parameter int PRESC_BITS  = 8,
  parameter int DWELL_TICKS = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stop,
  input  logic [PRESC_BITS-1:0] speed,
  input  logic [N_BIT-1:0]      cnt_in,
  output logic                  cnt_en,
  output logic                  cnt_dnu,
  output logic                  cnt_pl,
  output logic [N_BIT-1:0]      cnt_pin,
  output logic [MAX_POS:0]      led,
  output logic                  busy,
  output logic                  dir
);
  localparam int DW = DWELL_TICKS > 1 ? $clog2(DWELL_TICKS) : 1;
  localparam logic [N_BIT-1:0] MAX_V = N_BIT'(MAX_POS);
  typedef enum logic [2:0] {IDLE, LOAD, RUN_UP, DWELL_HI, RUN_DOWN, DWELL_LO} state_t;
  state_t state, nxt;
  logic [PRESC_BITS-1:0] presc;
  logic [DW-1:0] dwell;
  logic running, in_dwell, tick, dwell_done;
  logic [MAX_POS:0] led_nxt;
  function automatic logic [MAX_POS:0] onehot(input logic [N_BIT-1:0] v);
    onehot = '0;
    for (int i = 0; i <= MAX_POS; i++) onehot[i] = v == N_BIT'(i);
  endfunction
  assign running    = state inside {RUN_UP, DWELL_HI, RUN_DOWN, DWELL_LO};
  assign in_dwell   = state inside {DWELL_HI, DWELL_LO};
  assign tick       = running && presc >= speed;
  assign dwell_done = dwell == DW'(DWELL_TICKS - 1);
  // state register
  always_ff @(posedge clk)
    state <= rst ? IDLE : nxt;
  // next state; stop overrides everything outside IDLE
  always_comb begin
    nxt = state;
    case (state)
      IDLE:     nxt = start && !stop ? LOAD : IDLE;
      LOAD:     nxt = RUN_UP;
      RUN_UP:   nxt = tick && cnt_in >= MAX_V ? DWELL_HI : RUN_UP;
      DWELL_HI: nxt = tick && dwell_done ? RUN_DOWN : DWELL_HI;
      RUN_DOWN: nxt = tick && cnt_in == '0 ? DWELL_LO : RUN_DOWN;
      DWELL_LO: nxt = tick && dwell_done ? RUN_UP : DWELL_LO;
      default:  nxt = IDLE;
    endcase
    if (stop && state != IDLE) nxt = IDLE;
  end
  // counter controls; enable suppressed while stop aborts the scan
  always_comb begin
    cnt_pl  = state == LOAD;
    cnt_dnu = state == RUN_DOWN;
    cnt_pin = '0;
    busy    = state != IDLE;
    dir     = state inside {RUN_DOWN, DWELL_LO};
    cnt_en  = !stop && (state == LOAD
              || (state == RUN_UP && tick && cnt_in < MAX_V)
              || (state == RUN_DOWN && tick && cnt_in != '0));
  end
  // prescaler and dwell counter restart on every state change
  always_ff @(posedge clk) begin
    presc <= rst || nxt != state || !running || tick ? '0 : presc + 1'b1;
    dwell <= rst || nxt != state || !in_dwell ? '0 : tick ? dwell + 1'b1 : dwell;
  end
`ifdef SUPERCAR_TRAIL_EN
  logic [N_BIT-1:0] last_pos, prev_pos, prev_nxt;
  assign prev_nxt = state == LOAD ? '0 : busy && cnt_in != last_pos ? last_pos : prev_pos;
  assign led_nxt  = onehot(cnt_in) | onehot(prev_nxt);
  // remember the previous distinct position for the trail
  always_ff @(posedge clk) begin
    last_pos <= rst || state == LOAD ? '0 : cnt_in;
    prev_pos <= rst ? '0 : prev_nxt;
  end
`else
  assign led_nxt = onehot(cnt_in);
`endif
  // registered LED bar, dark while idle
  always_ff @(posedge clk)
    led <= rst || !busy ? '0 : led_nxt;
endmodule

// File: tb/tb_supercar_seq.sv
// tb_supercar_seq: closed-loop directed bench with an up/down loadable counter model
module tb_supercar_seq;
`ifdef SUPERCAR_TRAIL_EN
  localparam bit TRAIL = 1'b1;
`else
  localparam bit TRAIL = 1'b0;
`endif
  logic clk = 0, rst, start, stop;
  logic [7:0] speed, led;
  logic [3:0] cnt_in, cnt_pin;
  logic cnt_en, cnt_dnu, cnt_pl, busy, dir;
  int n_chk = 0, n_err = 0, en_cnt;
  supercar_seq dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .speed(speed),
    .cnt_in(cnt_in), .cnt_en(cnt_en), .cnt_dnu(cnt_dnu), .cnt_pl(cnt_pl),
    .cnt_pin(cnt_pin), .led(led), .busy(busy), .dir(dir)
  );
  always #5 clk = ~clk;
  always_ff @(posedge clk)
    if (rst) cnt_in <= '0;
    else if (cnt_en) cnt_in <= cnt_pl ? cnt_pin : cnt_dnu ? cnt_in - 1'b1 : cnt_in + 1'b1;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic tick_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  function automatic logic [7:0] exp_led(input int cur, input int prev, input bit has_prev);
    logic [7:0] one = 8'd1;
    exp_led = (one << cur) | (TRAIL && has_prev ? one << prev : 8'd0);
  endfunction
  initial begin
    rst = 1; start = 0; stop = 0; speed = 8'd3;
    tick_n(2);
    chk("rst_busy", busy, 0);
    chk("rst_led", led, 0);
    chk("rst_en", cnt_en, 0);
    chk("rst_pl", cnt_pl, 0);
    chk("rst_dnu", cnt_dnu, 0);
    chk("rst_pin", cnt_pin, 0);
    chk("rst_dir", dir, 0);
    rst = 0; start = 1;
    tick_n(1);
    start = 0; #1;
    chk("load_pl", cnt_pl, 1);
    chk("load_en", cnt_en, 1);
    chk("load_pin", cnt_pin, 0);
    chk("load_busy", busy, 1);
    for (int p = 0; p < 7; p++) begin
      repeat (3) begin tick_n(1); chk("up_gap_en", cnt_en, 0); end
      tick_n(1);
      chk("up_en", cnt_en, 1);
      chk("up_dnu", cnt_dnu, 0);
      chk("up_pos", cnt_in, p);
      chk("up_led", led, exp_led(p, p - 1, p > 0));
    end
    repeat (12) begin tick_n(1); chk("dwell_en", cnt_en, 0); end
    chk("top_led", led, exp_led(7, 6, 1));
    chk("top_dir", dir, 0);
    repeat (3) begin tick_n(1); chk("dn_gap_en", cnt_en, 0); chk("dn_dir", dir, 1); end
    tick_n(1);
    chk("dn_en", cnt_en, 1);
    chk("dn_dnu", cnt_dnu, 1);
    chk("dn_pos", cnt_in, 7);
    tick_n(2);
    chk("dn_led", led, exp_led(6, 7, 1));
    tick_n(10);
    chk("pre_stop_pos", cnt_in, 4);
    stop = 1; #1;
    chk("stop_en", cnt_en, 0);
    tick_n(1);
    stop = 0;
    chk("stop_busy", busy, 0);
    chk("stop_en2", cnt_en, 0);
    chk("stop_led", led, exp_led(4, 5, 1));
    chk("stop_hold", cnt_in, 4);
    tick_n(1);
    chk("stop_led_off", led, 0);
    chk("stop_hold2", cnt_in, 4);
    start = 1; stop = 1;
    tick_n(1);
    chk("clash_busy", busy, 0);
    stop = 0;
    tick_n(1);
    start = 0;
    chk("restart_pl", cnt_pl, 1);
    tick_n(1);
    chk("restart_pos", cnt_in, 0);
    chk("restart_busy", busy, 1);
    tick_n(20);
    chk("pre_rst_pos", cnt_in, 5);
    rst = 1;
    tick_n(1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_led", led, 0);
    chk("mid_rst_en", cnt_en, 0);
    chk("mid_rst_dir", dir, 0);
    chk("mid_rst_pos", cnt_in, 0);
    rst = 0;
    repeat (4) begin tick_n(1); chk("idle_en", cnt_en, 0); end
    speed = 8'd0; start = 1;
    tick_n(1);
    start = 0;
    en_cnt = 0;
    for (int i = 1; i <= 20; i++) begin
      tick_n(1);
      if (cnt_en) en_cnt++;
      if (i == 10) chk("fast_dir_hi", dir, 0);
      if (i == 11) begin chk("fast_dir_dn", dir, 1); chk("fast_dnu", cnt_dnu, 1); end
    end
    chk("fast_en_count", en_cnt, 14);
    chk("fast_lo_dir", dir, 1);
    chk("fast_lo_pos", cnt_in, 0);
    tick_n(1);
    chk("fast_wrap_en", cnt_en, 1);
    chk("fast_wrap_dnu", cnt_dnu, 0);
    chk("fast_wrap_dir", dir, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
